call_request_register: RTL and testbench
========================================

Name: call_request_register

Overview:
- Consumer side of the push-button path. Takes single-cycle call pulses from the per-button debouncers and latches them as pending floor requests.
- Drives the button lamps.
- Runs an up/down/idle scan state machine and presents the next target floor to the elevator motion controller.
- Clears a request when the car stops with doors open at that floor, and reports each service with a pulse.

Parameters:
- NUM_FLOORS, 4, number of floors and call buttons (2..16).
- FLOOR_W, 2, width of floor index; must be at least clog2(NUM_FLOORS).
- BLINK_DIV, 25000000, clk cycles per lamp blink half-period (used only with the optional feature).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- call_pulse  in  NUM_FLOORS  one-cycle request pulses from the debouncers; bit i = floor i.
- cur_floor  in  FLOOR_W  current car floor.
- at_floor  in  1  car stopped at cur_floor with doors open.
- pending  out  NUM_FLOORS  latched requests.
- lamp  out  NUM_FLOORS  button lamp drive.
- dir  out  2  scan state: 00 idle, 01 up, 10 down.
- target_valid  out  1  target_floor is meaningful.
- target_floor  out  FLOOR_W  next floor to travel to.
- served_pulse  out  1  one-cycle pulse when a request is serviced.

Behaviour:
- Reset: rst is asynchronous, active-high; clock is clk. On reset all outputs are 0: pending, lamp, dir=IDLE, target_valid, target_floor, served_pulse.
- Set rule: if call_pulse[i] is high at edge k, pending[i]=1 after edge k.
  - Exception: at_floor=1 and cur_floor==i at the same edge. The call is not latched and served_pulse=1 after edge k.
- Clear rule: at any edge where at_floor=1 and cur_floor==i with pending[i]=1, pending[i]=0 and served_pulse=1 after that edge.
  - Clear has priority over a simultaneous set on the same floor.
  - At most one clear per edge.
- cur_floor >= NUM_FLOORS: no clear and no served_pulse. The FSM still compares numerically.
- served_pulse is never held longer than one cycle unless service recurs on consecutive edges.
- Repeated call_pulse on an already pending floor has no effect.
- Scan FSM is updated each edge from registered pending and cur_floor.
  - above = any pending[j] with j > cur_floor; below = any pending[j] with j < cur_floor.
  - IDLE: above -> UP; else below -> DOWN; else stay.
  - UP: above -> stay; else below -> DOWN; else IDLE.
  - DOWN: below -> stay; else above -> UP; else IDLE.
  - A pending request at cur_floor alone does not move the FSM; it waits for at_floor.
- Target outputs are registered from the current dir and pending (one-edge lag behind dir):
  - UP: target_floor = lowest pending floor strictly above cur_floor.
  - DOWN: target_floor = highest pending floor strictly below cur_floor.
  - IDLE: target_valid=0 and target_floor holds its last value.
- End-to-end latency: call_pulse sampled at edge k -> pending at k -> dir at k+1 -> target_valid at k+2.
- Reset mid-operation: all pending requests are discarded; FSM returns to IDLE immediately.
- Non-blink lamp: lamp = pending (registered, same timing).

Optional Feature:
- Macro: CALL_LAMP_BLINK_EN.
- Defined: a counter runs 0..BLINK_DIV-1 and toggles a phase bit at wrap. lamp = pending & phase.
  - Counter resets to 0 and phase resets to 1 (lamps lit).
  - A newly set request forces phase=1 and the counter to 0 at the same edge, so the press is visible at once.
- Undefined: no counter or phase logic is instantiated; lamp = pending.

Decomposition:
- Shared package elevator_pkg:
  - DIR_IDLE=2'b00, DIR_UP=2'b01, DIR_DOWN=2'b10.
  - dir_t typedef (2-bit).
  - Floor-index width constant shared with the motion controller.
- Sub-module floor_priority_scan: combinational; inputs pending, cur_floor, dir. Outputs above, below, next_up, next_down, valid flags. Instantiated once.

Test Plan (NUM_FLOORS=4, BLINK_DIV=4):
- Reset then call_pulse=0100 at edge 1, cur_floor=0 -> pending=0100 after edge 1; dir=01 after edge 2; target_valid=1, target_floor=2 after edge 3.
- pending=1010, cur_floor=2, dir=UP -> target_floor=3. Then cur_floor=3, at_floor=1 -> pending=0010, served_pulse one cycle, dir becomes DOWN, target_floor=1.
- at_floor=1, cur_floor=1, call_pulse=0010 at the same edge -> pending stays 0000; served_pulse=1 for one cycle; dir stays IDLE.
- pending=0001 with cur_floor=0 only, at_floor=0 -> dir stays IDLE, target_valid=0. Then at_floor=1 clears it.
- rst pulsed asynchronously mid-cycle with pending=1111, dir=UP -> all outputs 0 immediately, before the next edge.
- With CALL_LAMP_BLINK_EN and pending=0100 -> lamp[2] toggles every 4 cycles. A new call on floor 0 -> lamp=0101 at the next edge, counter restarts.

Source files
------------

// File: rtl/elevator_pkg.sv
// ---------------------------------------------------------------------------
// elevator_pkg
// Types and constants shared by the elevator control blocks. The call request
// register and the motion controller both import this package.
//   dir_t         : scan direction encoding (idle / up / down)
//   ELEV_FLOOR_W  : floor-index width shared with the motion controller
// ---------------------------------------------------------------------------
package elevator_pkg;

    localparam int ELEV_FLOOR_W = 2;

    typedef enum logic [1:0] {
        DIR_IDLE = 2'b00,
        DIR_UP   = 2'b01,
        DIR_DOWN = 2'b10
    } dir_t;

endpackage

// File: rtl/floor_priority_scan.sv
// ---------------------------------------------------------------------------
// floor_priority_scan
// Combinational look-up of pending requests relative to the car position.
// Ports:
//   pending    in  latched requests, bit i = floor i
//   cur_floor  in  current car floor (compared numerically, may exceed range)
//   dir        in  current scan direction (dir_t encoding)
//   above      out some request strictly above cur_floor
//   below      out some request strictly below cur_floor
//   next_up    out lowest requested floor strictly above cur_floor
//   next_down  out highest requested floor strictly below cur_floor
//   sel_valid  out a target exists in the current scan direction
//   sel_floor  out that target (next_up for UP, next_down for DOWN)
// ---------------------------------------------------------------------------
module floor_priority_scan
    import elevator_pkg::*;
#(
    parameter int NUM_FLOORS = 4,
    parameter int FLOOR_W    = ELEV_FLOOR_W
) (
    input  logic [NUM_FLOORS-1:0] pending,
    input  logic [FLOOR_W-1:0]    cur_floor,
    input  logic [1:0]            dir,
    output logic                  above,
    output logic                  below,
    output logic [FLOOR_W-1:0]    next_up,
    output logic [FLOOR_W-1:0]    next_down,
    output logic                  sel_valid,
    output logic [FLOOR_W-1:0]    sel_floor
);

    always_comb begin
        above     = 1'b0;
        below     = 1'b0;
        next_up   = '0;
        next_down = '0;
        // Walk downwards so the last hit is the lowest floor above the car.
        for (int j = NUM_FLOORS - 1; j >= 0; j--) begin
            if (pending[j] && (FLOOR_W'(j) > cur_floor)) begin
                above   = 1'b1;
                next_up = FLOOR_W'(j);
            end
        end
        // Walk upwards so the last hit is the highest floor below the car.
        for (int j = 0; j < NUM_FLOORS; j++) begin
            if (pending[j] && (FLOOR_W'(j) < cur_floor)) begin
                below     = 1'b1;
                next_down = FLOOR_W'(j);
            end
        end
    end

    always_comb begin
        sel_valid = 1'b0;
        sel_floor = '0;
        if (dir == DIR_UP) begin
            sel_valid = above;
            sel_floor = next_up;
        end else if (dir == DIR_DOWN) begin
            sel_valid = below;
            sel_floor = next_down;
        end
    end

endmodule

// File: rtl/call_request_register.sv
// ---------------------------------------------------------------------------
// call_request_register
// Latches single-cycle call pulses as pending floor requests, drives the
// button lamps, runs the up/down/idle scan FSM and registers the next target
// floor for the motion controller. A request is cleared (and served_pulse
// raised for one cycle) when the car stands with doors open at that floor; a
// call made at the floor the car is already serving is absorbed the same way.
//
// Optional build macro CALL_LAMP_BLINK_EN: lamps blink with a half-period of
// BLINK_DIV clocks; a newly latched call restarts the blink in the lit phase.
// Without the macro lamp simply mirrors pending.
//
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   call_pulse    one-cycle call pulses, bit i = floor i
//   cur_floor     current car floor
//   at_floor      car stopped at cur_floor with doors open
//   pending       latched requests
//   lamp          button lamp drive
//   dir           scan state: 00 idle, 01 up, 10 down
//   target_valid  target_floor is meaningful
//   target_floor  next floor to travel to
//   served_pulse  one-cycle pulse per serviced request
// ---------------------------------------------------------------------------
module call_request_register
    import elevator_pkg::*;
#(
    parameter int NUM_FLOORS = 4,
    parameter int FLOOR_W    = ELEV_FLOOR_W,
    parameter int BLINK_DIV  = 25000000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_FLOORS-1:0] call_pulse,
    input  logic [FLOOR_W-1:0]    cur_floor,
    input  logic                  at_floor,
    output logic [NUM_FLOORS-1:0] pending,
    output logic [NUM_FLOORS-1:0] lamp,
    output logic [1:0]            dir,
    output logic                  target_valid,
    output logic [FLOOR_W-1:0]    target_floor,
    output logic                  served_pulse
);

    logic [NUM_FLOORS-1:0] pending_q;
    logic [NUM_FLOORS-1:0] pending_d;
    logic [NUM_FLOORS-1:0] svc_hit;
    logic                  served_d;
    logic                  served_q;
    dir_t                  dir_q;
    dir_t                  dir_d;
    logic                  target_valid_q;
    logic [FLOOR_W-1:0]    target_floor_q;

    logic                  above;
    logic                  below;
    logic [FLOOR_W-1:0]    next_up;
    logic [FLOOR_W-1:0]    next_down;
    logic                  sel_valid;
    logic [FLOOR_W-1:0]    sel_floor;

    // One-hot of the floor being serviced this edge. An out-of-range
    // cur_floor matches no bit, so it never clears or pulses. Only one bit
    // can be set, which limits clearing to one request per edge.
    always_comb begin
        svc_hit = '0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            svc_hit[i] = at_floor && (cur_floor == FLOOR_W'(i));
        end
    end

    // Clear wins over a same-edge call on the serviced floor; that call is
    // reported as served instead of being latched.
    assign pending_d = (pending_q | call_pulse) & ~svc_hit;
    assign served_d  = |(svc_hit & (pending_q | call_pulse));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_q <= '0;
            served_q  <= 1'b0;
        end else begin
            pending_q <= pending_d;
            served_q  <= served_d;
        end
    end

    floor_priority_scan #(
        .NUM_FLOORS (NUM_FLOORS),
        .FLOOR_W    (FLOOR_W)
    ) u_scan (
        .pending    (pending_q),
        .cur_floor  (cur_floor),
        .dir        (dir_q),
        .above      (above),
        .below      (below),
        .next_up    (next_up),
        .next_down  (next_down),
        .sel_valid  (sel_valid),
        .sel_floor  (sel_floor)
    );

    // Scan FSM. A request at cur_floor alone sets neither above nor below,
    // so the FSM stays put and waits for at_floor to clear it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dir_q <= DIR_IDLE;
        end else begin
            dir_q <= dir_d;
        end
    end

    always_comb begin
        dir_d = dir_q;
        case (dir_q)
            DIR_IDLE: begin
                if (above)      dir_d = DIR_UP;
                else if (below) dir_d = DIR_DOWN;
            end
            DIR_UP: begin
                if (above)      dir_d = DIR_UP;
                else if (below) dir_d = DIR_DOWN;
                else            dir_d = DIR_IDLE;
            end
            DIR_DOWN: begin
                if (below)      dir_d = DIR_DOWN;
                else if (above) dir_d = DIR_UP;
                else            dir_d = DIR_IDLE;
            end
            default: dir_d = DIR_IDLE;
        endcase
    end

    // Target follows the registered direction, one edge behind dir. With no
    // target in the current direction the last floor is kept for reference.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            target_valid_q <= 1'b0;
            target_floor_q <= '0;
        end else begin
            target_valid_q <= sel_valid;
            if (sel_valid) begin
                target_floor_q <= sel_floor;
            end
        end
    end

`ifdef CALL_LAMP_BLINK_EN
    localparam int BLINK_CW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    logic [BLINK_CW-1:0] blink_cnt;
    logic                phase;
    logic                new_set;

    // Only a call that actually becomes pending restarts the blink.
    assign new_set = |(call_pulse & ~pending_q & ~svc_hit);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blink_cnt <= '0;
            phase     <= 1'b1;
        end else if (new_set) begin
            blink_cnt <= '0;
            phase     <= 1'b1;
        end else if (blink_cnt == BLINK_CW'(BLINK_DIV - 1)) begin
            blink_cnt <= '0;
            phase     <= ~phase;
        end else begin
            blink_cnt <= blink_cnt + 1'b1;
        end
    end

    assign lamp = pending_q & {NUM_FLOORS{phase}};
`else
    // A non-positive divider is treated as lamps disabled.
    assign lamp = (BLINK_DIV > 0) ? pending_q : '0;
`endif

    assign pending      = pending_q;
    assign served_pulse = served_q;
    assign dir          = dir_q;
    assign target_valid = target_valid_q;
    assign target_floor = target_floor_q;

endmodule

// File: tb/tb_call_request_register.sv
// ---------------------------------------------------------------------------
// tb_call_request_register
// Directed bench for call_request_register (NUM_FLOORS=4, BLINK_DIV=4).
// Inputs change 1 time unit after a rising edge; outputs are checked there.
// ---------------------------------------------------------------------------
module tb_call_request_register;

    localparam int NF = 4;
    localparam int FW = 2;

    logic          clk;
    logic          rst;
    logic [NF-1:0] call_pulse;
    logic [FW-1:0] cur_floor;
    logic          at_floor;
    logic [NF-1:0] pending;
    logic [NF-1:0] lamp;
    logic [1:0]    dir;
    logic          target_valid;
    logic [FW-1:0] target_floor;
    logic          served_pulse;

    int n_chk  = 0;
    int n_fail = 0;

    call_request_register #(
        .NUM_FLOORS (NF),
        .FLOOR_W    (FW),
        .BLINK_DIV  (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .call_pulse   (call_pulse),
        .cur_floor    (cur_floor),
        .at_floor     (at_floor),
        .pending      (pending),
        .lamp         (lamp),
        .dir          (dir),
        .target_valid (target_valid),
        .target_floor (target_floor),
        .served_pulse (served_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst        = 1'b1;
        call_pulse = '0;
        cur_floor  = '0;
        at_floor   = 1'b0;
        tick();
        tick();
        check("rst_pending", pending, 0);
        check("rst_lamp", lamp, 0);
        check("rst_dir", dir, 0);
        check("rst_tvalid", target_valid, 0);
        check("rst_tfloor", target_floor, 0);
        check("rst_served", served_pulse, 0);
        rst = 1'b0;

        // Latency: call at edge 1, dir at edge 2, target at edge 3.
        call_pulse = 4'b0100;
        tick();
        call_pulse = '0;
        check("lat_pending", pending, 4'b0100);
        check("lat_lamp", lamp, 4'b0100);
        check("lat_dir0", dir, 2'b00);
        tick();
        check("lat_dir1", dir, 2'b01);
        check("lat_tv0", target_valid, 0);
        tick();
        check("lat_tv1", target_valid, 1);
        check("lat_tf", target_floor, 2);

        // Build pending=1110 while heading up.
        call_pulse = 4'b1010;
        tick();
        call_pulse = '0;
        check("up_pending", pending, 4'b1110);
        check("up_tf", target_floor, 2);
        // Serve floor 2: next target above is 3.
        cur_floor = 2; at_floor = 1'b1;
        tick();
        check("s2_pending", pending, 4'b1010);
        check("s2_served", served_pulse, 1);
        check("s2_dir", dir, 2'b01);
        check("s2_tf", target_floor, 3);
        check("s2_tv", target_valid, 1);
        // Serve floor 3: only floor 1 left, so turn down.
        cur_floor = 3;
        tick();
        check("s3_pending", pending, 4'b0010);
        check("s3_served", served_pulse, 1);
        check("s3_dir", dir, 2'b10);
        check("s3_tv", target_valid, 0);
        check("s3_tf_hold", target_floor, 3);
        at_floor = 1'b0;
        tick();
        check("dn_served", served_pulse, 0);
        check("dn_tv", target_valid, 1);
        check("dn_tf", target_floor, 1);
        // Serve floor 1: nothing left, back to idle.
        cur_floor = 1; at_floor = 1'b1;
        tick();
        check("s1_pending", pending, 0);
        check("s1_served", served_pulse, 1);
        check("s1_dir", dir, 2'b00);
        check("s1_tv", target_valid, 0);

        // Call at the floor being served is absorbed.
        call_pulse = 4'b0010;
        tick();
        call_pulse = '0; at_floor = 1'b0;
        check("abs_pending", pending, 0);
        check("abs_served", served_pulse, 1);
        check("abs_dir", dir, 2'b00);
        tick();
        check("abs_served_end", served_pulse, 0);

        // Request only at the car floor: FSM stays idle until at_floor.
        cur_floor = 0;
        call_pulse = 4'b0001;
        tick();
        check("here_pending", pending, 4'b0001);
        // Repeated call on an already pending floor changes nothing.
        tick();
        call_pulse = '0;
        check("rep_pending", pending, 4'b0001);
        check("rep_served", served_pulse, 0);
        tick();
        check("here_dir", dir, 2'b00);
        check("here_tv", target_valid, 0);
        at_floor = 1'b1;
        tick();
        at_floor = 1'b0;
        check("here_clr", pending, 0);
        check("here_served", served_pulse, 1);

`ifdef CALL_LAMP_BLINK_EN
        // New call restarts the blink lit; half-period is 4 clocks.
        call_pulse = 4'b0100;
        tick();
        call_pulse = '0;
        check("blk_on0", lamp, 4'b0100);
        tick(); tick(); tick();
        check("blk_on3", lamp, 4'b0100);
        tick();
        check("blk_off", lamp, 4'b0000);
        call_pulse = 4'b0001;
        tick();
        call_pulse = '0;
        check("blk_new", lamp, 4'b0101);
        tick(); tick(); tick();
        check("blk_new3", lamp, 4'b0101);
        tick();
        check("blk_new_off", lamp, 4'b0000);
`endif

        // Asynchronous reset mid-cycle while scanning up with all floors pending.
        call_pulse = 4'b1111;
        tick();
        call_pulse = '0;
        check("all_pending", pending, 4'b1111);
        tick();
        check("all_dir", dir, 2'b01);
        #2 rst = 1'b1;
        #1;
        check("arst_pending", pending, 0);
        check("arst_lamp", lamp, 0);
        check("arst_dir", dir, 0);
        check("arst_tv", target_valid, 0);
        check("arst_tf", target_floor, 0);
        check("arst_served", served_pulse, 0);
        #1 rst = 1'b0;
        tick();
        check("post_pending", pending, 0);
        check("post_dir", dir, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
